// File: rtl/image_fade_blitter.sv
// Game-over panel blitter: fetches a 240x180 12-bit image from a synchronous ROM
// and applies a frame-locked fade ramp, with VGA syncs kept aligned to the colour path.
module image_fade_blitter #(
  parameter int IMG_W           = 240,
  parameter int IMG_H           = 180,
  parameter int X0              = 344,
  parameter int Y0              = 181,
  parameter int ADDR_W          = 16,
  parameter int FRAMES_PER_STEP = 4
) (
  input  logic              dclk,
  input  logic              clr_n,
  input  logic [9:0]        hcount,
  input  logic [9:0]        vcount,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              show,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [11:0]       rom_data,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic              hsync,
  output logic              vsync,
  output logic              busy
);

  localparam logic [9:0] X_FIRST = 10'(X0);
  localparam logic [9:0] X_LAST  = 10'(X0 + IMG_W - 1);
  localparam logic [9:0] Y_FIRST = 10'(Y0);
  localparam logic [9:0] Y_LAST  = 10'(Y0 + IMG_H - 1);
  localparam logic [7:0] FCNT_LAST = 8'(FRAMES_PER_STEP - 1);

  typedef enum logic [1:0] {IDLE, FADE_IN, HOLD, FADE_OUT} state_t;

  state_t            state;
  logic [3:0]        level;
  logic [7:0]        fcnt;
  logic [ADDR_W-1:0] row_base;
  logic              vld_p1, vld_p2;
  logic              hs_p1, hs_p2, vs_p1, vs_p2;
  logic              in_rows, win, frame_tick, step_tick;

  // 4-bit channel times (level+1), top nibble of the 8-bit product
  function automatic logic [3:0] scale_px(input logic [3:0] px, input logic [3:0] lvl);
    logic [7:0] prod;
    prod = 8'(px) * 8'({1'b0, lvl} + 5'd1);
    return prod[7:4];
  endfunction

  assign in_rows    = (vcount >= Y_FIRST) && (vcount <= Y_LAST);
  assign win        = in_rows && (hcount >= X_FIRST) && (hcount <= X_LAST);
  assign frame_tick = (hcount == 10'd0) && (vcount == 10'd0);
  assign step_tick  = frame_tick && (fcnt == FCNT_LAST);

  // S1: address issue, window and sync capture
  always_ff @(posedge dclk or negedge clr_n) begin
    if (!clr_n) begin
      row_base <= '0;
      rom_addr <= '0;
      vld_p1   <= 1'b0;
      hs_p1    <= 1'b1;
      vs_p1    <= 1'b1;
    end else begin
      vld_p1 <= win;
      hs_p1  <= hsync_in;
      vs_p1  <= vsync_in;
      if (frame_tick)
        row_base <= '0;
      else if (hcount == X_LAST && in_rows)
        row_base <= row_base + ADDR_W'(IMG_W);
      if (win)
        rom_addr <= row_base + ADDR_W'(hcount - X_FIRST);
    end
  end

  // S2: ROM data in flight, window and syncs delayed to match
  always_ff @(posedge dclk or negedge clr_n) begin
    if (!clr_n) begin
      vld_p2 <= 1'b0;
      hs_p2  <= 1'b1;
      vs_p2  <= 1'b1;
    end else begin
      vld_p2 <= vld_p1;
      hs_p2  <= hs_p1;
      vs_p2  <= vs_p1;
    end
  end

  // S3: scaled colour and syncs to the pins
  always_ff @(posedge dclk or negedge clr_n) begin
    if (!clr_n) begin
      red   <= 4'd0;
      green <= 4'd0;
      blue  <= 4'd0;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else begin
      hsync <= hs_p2;
      vsync <= vs_p2;
      if (vld_p2 && state != IDLE) begin
        red   <= scale_px(rom_data[11:8], level);
        green <= scale_px(rom_data[7:4], level);
        blue  <= scale_px(rom_data[3:0], level);
      end else begin
        red   <= 4'd0;
        green <= 4'd0;
        blue  <= 4'd0;
      end
    end
  end

  // Direction follows show every cycle; level moves only on step_tick, and a
  // state change in the same cycle wins over the step.
  always_ff @(posedge dclk or negedge clr_n) begin
    if (!clr_n) begin
      state <= IDLE;
      level <= 4'd0;
      fcnt  <= 8'd0;
      busy  <= 1'b0;
    end else begin
      if (frame_tick)
        fcnt <= step_tick ? 8'd0 : fcnt + 8'd1;
      case (state)
        IDLE: begin
          level <= 4'd0;
          if (show) begin
            state <= FADE_IN;
            fcnt  <= 8'd0;
            busy  <= 1'b1;
          end
        end
        FADE_IN: begin
          if (!show)
            state <= FADE_OUT;
          else if (level == 4'd15)
            state <= HOLD;
          else if (step_tick) begin
            level <= level + 4'd1;
            if (level == 4'd14)
              state <= HOLD;
          end
        end
        HOLD: begin
          level <= 4'd15;
          if (!show) begin
            state <= FADE_OUT;
            fcnt  <= 8'd0;
          end
        end
        FADE_OUT: begin
          if (show)
            state <= FADE_IN;
          else if (level == 4'd0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (step_tick) begin
            level <= level - 4'd1;
            if (level == 4'd1) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_image_fade_blitter.sv
// Scoreboard bench for image_fade_blitter: directed hcount/vcount sequences with
// compressed frames; a negedge monitor pops expected pins, address and busy.
module tb_image_fade_blitter;
  localparam int IMG_W = 240, IMG_H = 180, X0 = 344, Y0 = 181, ADDR_W = 16, FPS = 2;

  logic              dclk = 1'b0, clr_n = 1'b0;
  logic [9:0]        hcount = '0, vcount = '0;
  logic              hsync_in = 1'b1, vsync_in = 1'b1, show = 1'b0;
  logic [ADDR_W-1:0] rom_addr;
  logic [11:0]       rom_data = '0;
  logic [3:0]        red, green, blue;
  logic              hsync, vsync, busy;

  image_fade_blitter #(.IMG_W(IMG_W), .IMG_H(IMG_H), .X0(X0), .Y0(Y0), .ADDR_W(ADDR_W),
                       .FRAMES_PER_STEP(FPS)) dut (
    .dclk(dclk), .clr_n(clr_n), .hcount(hcount), .vcount(vcount), .hsync_in(hsync_in),
    .vsync_in(vsync_in), .show(show), .rom_addr(rom_addr), .rom_data(rom_data),
    .red(red), .green(green), .blue(blue), .hsync(hsync), .vsync(vsync), .busy(busy));

  always #20 dclk = ~dclk;

  logic rom_full = 1'b0;
  always @(posedge dclk) rom_data <= rom_full ? 12'hFFF : rom_addr[11:0];

  int cyc = 0;
  always @(posedge dclk) cyc <= cyc + 1;

  typedef struct { int due; logic [15:0] val; } exp_t;
  exp_t qp[$], qa[$], qb[$];
  int applied = 0, miscompares = 0;
  int last_addr = 0, exp_level = 0;
  bit exp_on = 0;

  always @(negedge dclk) begin
    exp_t e;
    logic [15:0] act;
    while (qp.size() > 0 && qp[0].due <= cyc) begin
      e = qp.pop_front(); applied++;
      act = {2'b00, hsync, vsync, red, green, blue};
      if (act !== e.val) begin
        miscompares++;
        $display("FAIL pins cyc=%0d got=%h expected=%h", cyc, act, e.val);
      end
    end
    while (qa.size() > 0 && qa[0].due <= cyc) begin
      e = qa.pop_front(); applied++;
      act = rom_addr;
      if (act !== e.val) begin
        miscompares++;
        $display("FAIL rom_addr cyc=%0d got=%0d expected=%0d", cyc, act, e.val);
      end
    end
    while (qb.size() > 0 && qb[0].due <= cyc) begin
      e = qb.pop_front(); applied++;
      act = {15'd0, busy};
      if (act !== e.val) begin
        miscompares++;
        $display("FAIL busy cyc=%0d got=%0d expected=%0d", cyc, act, e.val);
      end
    end
  end

  function automatic logic [3:0] sc(input logic [3:0] c, input int lvl);
    int p;
    p = int'(c) * (lvl + 1);
    return 4'(p >> 4);
  endfunction

  task automatic step(input int h, input int v);
    logic [11:0] px;
    logic [3:0] r, g, b;
    bit w;
    @(posedge dclk); #1;
    hcount = 10'(h); vcount = 10'(v);
    hsync_in = !(h >= 656 && h < 752);
    vsync_in = !(v == 490 || v == 491);
    w = (h >= X0) && (h < X0 + IMG_W) && (v >= Y0) && (v < Y0 + IMG_H);
    if (w) last_addr = (v - Y0) * IMG_W + (h - X0);
    qa.push_back(exp_t'{cyc + 1, 16'(last_addr)});
    px = rom_full ? 12'hFFF : 12'(last_addr);
    r = 4'd0; g = 4'd0; b = 4'd0;
    if (w && exp_on) begin
      r = sc(px[11:8], exp_level); g = sc(px[7:4], exp_level); b = sc(px[3:0], exp_level);
    end
    qp.push_back(exp_t'{cyc + 3, {2'b00, hsync_in, vsync_in, r, g, b}});
  endtask

  task automatic chk_busy(input bit b);
    qb.push_back(exp_t'{cyc, {15'd0, b}});
  endtask

  task automatic chk_reset();
    qp.push_back(exp_t'{cyc, 16'h3000});
    qa.push_back(exp_t'{cyc, 16'h0000});
    qb.push_back(exp_t'{cyc, 16'h0000});
  endtask

  task automatic filler(input int n);
    for (int i = 0; i < n; i++) step(0, 10);
  endtask

  // One compressed frame: tick, then probes around the window corner and row 2.
  task automatic mini_frame(input int lvl, input bit on);
    exp_level = lvl; exp_on = on;
    step(0, 0);
    step(X0 - 1, Y0);
    step(X0, Y0);
    step(X0 + 5, Y0);
    step(X0 + 239, Y0);
    step(X0 + 240, Y0);
    step(X0 + 5, Y0 + 1);
    step(X0 + 239, Y0 + 1);
    filler(3);
  endtask

  initial begin
    int vl[8];
    vl = '{0, 1, Y0, 489, 490, 491, 492, 520};

    // reset values
    clr_n = 1'b0;
    @(posedge dclk); #1; chk_reset();
    @(posedge dclk); #1; chk_reset();
    clr_n = 1'b1;

    // idle free-run: syncs delayed by 3, colour 0, busy 0
    for (int i = 0; i < 8; i++)
      for (int h = 0; h < 800; h++) step(h, vl[i]);
    chk_busy(1'b0);

    // fade in with address-pattern ROM
    rom_full = 1'b0;
    show = 1'b1; exp_on = 1'b1;
    step(0, 10); chk_busy(1'b1);
    filler(3);
    for (int f = 1; f <= FPS * 15 + 2; f++) mini_frame((f / FPS > 15) ? 15 : f / FPS, 1'b1);
    chk_busy(1'b1);

    // full window sweep in HOLD: every address, unscaled data
    exp_level = 15;
    step(0, 0);
    for (int v = Y0; v < Y0 + IMG_H; v++)
      for (int h = X0 - 1; h <= X0 + IMG_W; h++) step(h, v);
    filler(4);
    mini_frame(15, 1'b1);

    // fade out with all-ones ROM: channel value equals level
    rom_full = 1'b1;
    filler(4);
    show = 1'b0;
    step(0, 10); filler(3);
    for (int f = 1; f <= 12; f++) mini_frame(15 - f / FPS, 1'b1);
    show = 1'b1;
    step(0, 10); filler(3);
    for (int f = 1; f <= 4; f++) mini_frame(9 + f / FPS, 1'b1);
    show = 1'b0;
    step(0, 10); filler(3);
    for (int f = 1; f <= 22; f++) mini_frame(11 - f / FPS, (11 - f / FPS) > 0);
    chk_busy(1'b0);
    mini_frame(0, 1'b0);

    // fade in to level 6, then reset mid-frame
    show = 1'b1; exp_on = 1'b1;
    step(0, 10); chk_busy(1'b1);
    filler(3);
    for (int f = 1; f <= 12; f++) mini_frame(f / FPS, 1'b1);
    step(0, 0);
    step(X0, Y0);
    step(X0 + 1, Y0);
    @(posedge dclk); #1;
    clr_n = 1'b0;
    hcount = 10'd0; vcount = 10'd20;
    qp.delete(); qa.delete(); qb.delete();
    chk_reset();
    @(posedge dclk); #1; chk_reset();
    clr_n = 1'b1;
    last_addr = 0; exp_level = 0; exp_on = 1'b1;
    step(0, 20); chk_busy(1'b1);
    filler(3);
    for (int f = 1; f <= 4; f++) mini_frame(f / FPS, 1'b1);

    filler(6);
    repeat (5) @(posedge dclk);
    #1;
    if (qp.size() + qa.size() + qb.size() != 0) begin
      miscompares++;
      $display("FAIL drain pending=%0d expected=0", qp.size() + qa.size() + qb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule
